// File: rtl/alu_pkg.sv
// Shared opcodes, status bit positions and FSM states for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_NOT = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_V = 2;
    localparam int FLG_C = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial-product step per clock, WIDTH steps per product.
// o_done/o_product are valid combinationally during the final step's cycle.
module alu_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int CW = $clog2(WIDTH);

    logic             r_run;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_nxt;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_done    = r_run && (r_cnt == CW'(WIDTH - 1));
    assign o_product = w_acc_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_run    <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (r_run) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (o_done)
                r_run <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides, {C,V,N,Z} status and an iterative multiply.
// Single-cycle ops retire one clock after accept; MUL takes WIDTH further clocks.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter bit FLAGS_ALL_OPS = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic [2:0]       aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       status,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_init;
    logic [WIDTH-1:0] r_out;
    logic [3:0]       r_status;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_product;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_v;
    logic             w_c;
    logic [3:0]       w_flags;
    logic [3:0]       w_mul_flags;
    logic             w_upd_status;

    // r_init keeps in_ready low until the first clock after reset release
    assign in_ready   = r_init & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready));
    assign w_accept   = in_valid & in_ready;
    assign w_is_mul   = (aluop == ALU_MUL);
    assign out_valid  = (r_state == ST_DONE);
    assign busy       = (r_state == ST_BUSY);
    assign out        = r_out;
    assign status     = r_status;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_start   (w_accept & w_is_mul),
        .i_a       (ain),
        .i_b       (bin),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    assign w_sum  = {1'b0, ain} + {1'b0, bin};
    assign w_diff = {1'b0, ain} - {1'b0, bin};

    always_comb begin
        w_res = '0;
        w_v   = 1'b0;
        w_c   = 1'b0;
        case (aluop)
            ALU_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_v   = (ain[WIDTH-1] == bin[WIDTH-1]) & (w_sum[WIDTH-1] != ain[WIDTH-1]);
                w_c   = w_sum[WIDTH];
            end
            ALU_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_v   = (ain[WIDTH-1] != bin[WIDTH-1]) & (w_diff[WIDTH-1] != ain[WIDTH-1]);
                w_c   = ~w_diff[WIDTH];
            end
            ALU_AND: w_res = ain & bin;
            ALU_NOT: w_res = ~bin;
            ALU_OR:  w_res = ain | bin;
            ALU_XOR: w_res = ain ^ bin;
            ALU_SHL: w_res = ain << bin[SW-1:0];
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_flags              = '0;
        w_flags[FLG_Z]       = (w_res == '0);
        w_flags[FLG_N]       = w_res[WIDTH-1];
        w_flags[FLG_V]       = w_v;
        w_flags[FLG_C]       = w_c;
        w_mul_flags          = '0;
        w_mul_flags[FLG_Z]   = (w_product == '0);
        w_mul_flags[FLG_N]   = w_product[WIDTH-1];
    end

    assign w_upd_status = FLAGS_ALL_OPS | (aluop == ALU_SUB);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_is_mul ? ST_BUSY : ST_DONE;
            ST_BUSY: if (w_mul_done) w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (w_accept)
                    w_state_nxt = w_is_mul ? ST_BUSY : ST_DONE;
                else if (out_ready)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_init   <= 1'b0;
            r_out    <= '0;
            r_status <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_init  <= 1'b1;
            if (w_accept && !w_is_mul) begin
                r_out <= w_res;
                if (w_upd_status)
                    r_status <= w_flags;
            end else if ((r_state == ST_BUSY) && w_mul_done) begin
                r_out <= w_product;
                if (FLAGS_ALL_OPS)
                    r_status <= w_mul_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: two instances (status on SUB only / on all ops) share stimulus;
// expected results come from a plain-arithmetic model and are checked by a separate monitor.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  st0;
        logic [3:0]  st1;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [2:0]  aluop;
    logic        out_ready;
    logic        ir0, ov0, busy0, ir1, ov1, busy1;
    logic [15:0] out0, out1;
    logic [3:0]  st0, st1;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    bit          rnd      = 1'b0;
    logic [3:0]  m_st0    = 4'd0;
    logic [3:0]  m_st1    = 4'd0;
    exp_t        q[$];

    alu_seq #(.WIDTH(16), .FLAGS_ALL_OPS(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir0),
        .ain(ain), .bin(bin), .aluop(aluop), .out_valid(ov0), .out_ready(out_ready),
        .out(out0), .status(st0), .busy(busy0)
    );

    alu_seq #(.WIDTH(16), .FLAGS_ALL_OPS(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir1),
        .ain(ain), .bin(bin), .aluop(aluop), .out_valid(ov1), .out_ready(out_ready),
        .out(out1), .status(st1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic [3:0] f);
        longint ua, ub, full;
        logic   v, c;
        ua = longint'(a);
        ub = longint'(b);
        full = 0;
        v = 1'b0;
        c = 1'b0;
        case (op)
            ALU_ADD: begin full = ua + ub; c = (full > 65535); end
            ALU_SUB: begin full = ua - ub; c = (ua >= ub); end
            ALU_AND: full = ua & ub;
            ALU_NOT: full = ~ub;
            ALU_OR:  full = ua | ub;
            ALU_XOR: full = ua ^ ub;
            ALU_SHL: full = ua << (ub % 16);
            default: full = ua * ub;
        endcase
        r = full[15:0];
        if (op == ALU_ADD) v = (a[15] == b[15]) && (r[15] != a[15]);
        if (op == ALU_SUB) v = (a[15] != b[15]) && (r[15] != a[15]);
        f = {c, v, r[15], (r == 16'd0)};
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [3:0]  f;
        int          n;
        n = 0;
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        in_valid = 1'b1;
        aluop    = op;
        ain      = a;
        bin      = b;
        forever begin
            @(negedge clk);
            if (ir0) break;
            n++;
            if (n > 200) begin
                chk("issue_timeout", 32'(n), 32'd0);
                in_valid = 1'b0;
                return;
            end
            if (rnd) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        @(posedge clk);
        model(op, a, b, r, f);
        if (op == ALU_SUB) m_st0 = f;
        m_st1 = f;
        q.push_back('{res: r, st0: m_st0, st1: m_st1});
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: retire checks against the scoreboard, plus hold-stability while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && ov0) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else if (out_ready) begin
                e = q.pop_front();
                chk("out0", 32'(out0), 32'(e.res));
                chk("status0", 32'(st0), 32'(e.st0));
                chk("out_valid1", 32'(ov1), 32'd1);
                chk("out1", 32'(out1), 32'(e.res));
                chk("status1", 32'(st1), 32'(e.st1));
            end else begin
                chk("hold_out", 32'(out0), 32'(q[0].res));
                chk("hold_status", 32'(st0), 32'(q[0].st0));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int bsy;
        bit done;
        int prev;
        int n;
        logic [3:0] saved;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        ain       = '0;
        bin       = '0;
        aluop     = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(out0), 32'd0);
        chk("rst_status", 32'(st0), 32'd0);
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_in_ready", 32'(ir0), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(ir0), 32'd1);
        chk("in_ready1_after_rst", 32'(ir1), 32'd1);

        // SUB with borrow, then equal operands; latency 1
        out_ready = 1'b1;
        sync();
        issue(ALU_SUB, 16'd2, 16'd5);
        chk("sub_latency1", 32'(ov0), 32'd1);
        issue(ALU_SUB, 16'd5, 16'd5);
        repeat (2) sync();

        // Signed overflow corners
        issue(ALU_SUB, 16'h8000, 16'h0001);
        issue(ALU_ADD, 16'h7FFF, 16'h0001);
        repeat (2) sync();

        // MUL latency and in_ready during BUSY
        issue(ALU_MUL, 16'd3, 16'd7);
        bsy  = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ov0) done = 1'b1;
            else begin
                if (busy0 && busy1) bsy++;
                chk("mul_in_ready_low", 32'(ir0), 32'd0);
            end
        end
        chk("mul_done_seen", 32'(done), 32'd1);
        chk("mul_busy_cycles", 32'(bsy), 32'd16);
        sync();

        // Back-pressure: result held, new op refused until release
        out_ready = 1'b0;
        sync();
        issue(ALU_ADD, 16'd1, 16'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", 32'(ov0), 32'd1);
            chk("stall_out", 32'(out0), 32'd2);
        end
        sync();
        in_valid = 1'b1;
        aluop    = ALU_ADD;
        ain      = 16'd3;
        bin      = 16'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready_low", 32'(ir0), 32'd0);
            chk("stall_out_kept", 32'(out0), 32'd2);
        end
        sync();
        out_ready = 1'b1;
        issue(ALU_ADD, 16'd3, 16'd4);
        repeat (2) sync();

        // Back-to-back AND stream, one accept per cycle
        saved = st0;
        prev  = 0;
        for (int i = 0; i < 4; i++) begin
            issue(ALU_AND, 16'($urandom), 16'($urandom));
            if (i > 0) chk("stream_rate", 32'(acc_cyc - prev), 32'd1);
            prev = acc_cyc;
        end
        repeat (2) sync();
        chk("and_status0_hold", 32'(st0), 32'(saved));

        // Async reset in the middle of a multiply
        issue(ALU_MUL, 16'h1234, 16'h0FF1);
        repeat (8) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_out", 32'(out0), 32'd0);
        chk("abort_status", 32'(st0), 32'd0);
        chk("abort_status1", 32'(st1), 32'd0);
        chk("abort_out_valid", 32'(ov0), 32'd0);
        chk("abort_busy", 32'(busy0), 32'd0);
        q.delete();
        m_st0 = 4'd0;
        m_st1 = 4'd0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) sync();
        issue(ALU_SUB, 16'd9, 16'd4);
        repeat (2) sync();

        // Randomized traffic with random back-pressure
        rnd = 1'b1;
        for (int i = 0; i < 200; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
            if ($urandom_range(0, 3) == 0) sync();
        end
        rnd       = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            sync();
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
